// File: rtl/eth_pkt_pkg.sv
// eth_pkt_pkg: shared types and constants for the Ethernet packet FIFO read side.
//   state_t        scheduler FSM states
//   ETH_DATA_WIDTH FIFO / TX word width
//   ETH_FIFO_AW    FIFO address width (levels and counters are one bit wider)
//   ETH_BYTE_NUM_W width of the TX core byte-count field
package eth_pkt_pkg;

    localparam int unsigned ETH_DATA_WIDTH = 32;
    localparam int unsigned ETH_FIFO_AW    = 10;
    localparam int unsigned ETH_BYTE_NUM_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StXfer,
        StWaitDone,
        StGap
    } state_t;

endpackage

// File: rtl/eth_pkt_gap_timer.sv
// eth_pkt_gap_timer: inter-packet gap counter.
//   clk, rst : clock, asynchronous active-high reset
//   load     : clear the count (entry into the gap)
//   count    : advance while the gap is in progress
//   expire   : last gap cycle; the gap lasts max(IFG_CYCLES, 1) cycles
module eth_pkt_gap_timer #(
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int unsigned CW = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    // With 0 or 1 gap cycles the very first gap cycle is also the last.
    assign expire = (IFG_CYCLES <= 1) ? 1'b1 : (cnt_q == CW'(IFG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/eth_pkt_rd_sched.sv
// eth_pkt_rd_sched: read-side packet scheduler between the packet FIFO and the UDP TX core.
// Waits for a whole packet to be buffered, pulses tx_start_en, forwards the TX core's word
// requests to the FIFO read enable, then enforces an inter-packet gap.
//   clk, rst       : FIFO rd_clk, asynchronous active-high reset
//   cfg_pkt_words  : packet length in words, sampled while idle
//   fifo_rd_data   : FIFO read data (one cycle after fifo_rd_en)
//   fifo_empty     : FIFO empty
//   fifo_rd_level  : FIFO read-side water level
//   fifo_rd_en     : FIFO read enable
//   tx_start_en    : one-cycle start pulse to the TX core
//   tx_byte_num    : packet byte count, held until the next start
//   tx_req         : TX core word request
//   tx_data        : word to the TX core (pass-through of fifo_rd_data)
//   tx_done        : TX core end-of-packet pulse
//   busy           : scheduler not idle
//   underflow_err  : sticky; a request arrived while the FIFO was empty
// Optional statistics outputs (stat_pkt_cnt, stat_underflow_cnt) when
// ETH_PKT_RD_SCHED_STATS_EN is defined.
module eth_pkt_rd_sched
    import eth_pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ETH_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = ETH_FIFO_AW,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned IFG_CYCLES     = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH:0]       cfg_pkt_words,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    input  logic                      fifo_empty,
    input  logic [ADDR_WIDTH:0]       fifo_rd_level,
    output logic                      fifo_rd_en,
    output logic                      tx_start_en,
    output logic [ETH_BYTE_NUM_W-1:0] tx_byte_num,
    input  logic                      tx_req,
    output logic [DATA_WIDTH-1:0]     tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      underflow_err
`ifdef ETH_PKT_RD_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_pkt_cnt,
    output logic [15:0]               stat_underflow_cnt
`endif
);

    state_t                    state_q;
    logic [ADDR_WIDTH:0]       pkt_len_q;
    logic [ADDR_WIDTH:0]       rd_cnt_q;
    logic [ADDR_WIDTH:0]       rd_cnt_next;
    logic                      tx_start_en_q;
    logic [ETH_BYTE_NUM_W-1:0] tx_byte_num_q;
    logic                      underflow_q;
    logic                      rd_ok;
    logic                      underflow_hit;
    logic                      in_pkt;
    logic                      gap_load;
    logic                      gap_expire;

    assign rd_ok = (state_q == StXfer) && tx_req && !fifo_empty && (rd_cnt_q < pkt_len_q);
    assign underflow_hit = (state_q == StXfer) && tx_req && fifo_empty;
    assign rd_cnt_next = rd_cnt_q + 1'b1;

    // tx_done is honoured in START/XFER (abort) and WAIT_DONE (normal end).
    assign in_pkt = (state_q == StStart) || (state_q == StXfer) || (state_q == StWaitDone);
    assign gap_load = in_pkt && tx_done;

    assign fifo_rd_en    = rd_ok;
    assign tx_data       = fifo_rd_data;
    assign tx_start_en   = tx_start_en_q;
    assign tx_byte_num   = tx_byte_num_q;
    assign busy          = (state_q != StIdle);
    assign underflow_err = underflow_q;

    eth_pkt_gap_timer #(
        .IFG_CYCLES (IFG_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (gap_load),
        .count  (state_q == StGap),
        .expire (gap_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pkt_len_q     <= '0;
            rd_cnt_q      <= '0;
            tx_start_en_q <= 1'b0;
            tx_byte_num_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            tx_start_en_q <= 1'b0;
            if (underflow_hit) begin
                underflow_q <= 1'b1;
            end
            if (rd_ok) begin
                rd_cnt_q <= rd_cnt_next;
            end
            case (state_q)
                StIdle: begin
                    pkt_len_q <= cfg_pkt_words;
                    rd_cnt_q  <= '0;
                    if ((cfg_pkt_words != '0) && (fifo_rd_level >= cfg_pkt_words)) begin
                        state_q       <= StStart;
                        tx_start_en_q <= 1'b1;
                        // Same value as pkt_len, which is latched on this edge.
                        tx_byte_num_q <= ETH_BYTE_NUM_W'(cfg_pkt_words * BYTES_PER_WORD);
                    end
                end
                StStart: begin
                    state_q <= tx_done ? StGap : StXfer;
                end
                StXfer: begin
                    if (tx_done) begin
                        state_q <= StGap;
                    end else if (rd_ok && (rd_cnt_next == pkt_len_q)) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (tx_done) begin
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (gap_expire) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef ETH_PKT_RD_SCHED_STATS_EN
    logic [31:0] stat_pkt_q;
    logic [15:0] stat_uf_q;

    assign stat_pkt_cnt       = stat_pkt_q;
    assign stat_underflow_cnt = stat_uf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_q <= '0;
            stat_uf_q  <= '0;
        end else begin
            // Only completed packets count; aborts are excluded.
            if ((state_q == StWaitDone) && tx_done && (stat_pkt_q != '1)) begin
                stat_pkt_q <= stat_pkt_q + 1'b1;
            end
            if (underflow_hit && (stat_uf_q != '1)) begin
                stat_uf_q <= stat_uf_q + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/eth_pkt_rd_sched.md
Name: eth_pkt_rd_sched

Overview:
- Read-side packet scheduler for the 32-bit Ethernet packet FIFO (ADDR_WIDTH=10, OUT_REG=0).
- Waits until one full packet is buffered (rd_water_level), then starts the UDP transmitter.
- Drives the FIFO read enable from the transmitter's per-word requests and enforces an inter-packet gap.
- Sits between the FIFO read port and the UDP TX core, in the FIFO's rd_clk domain.

Parameters:
- DATA_WIDTH, 32, FIFO/TX word width in bits
- ADDR_WIDTH, 10, FIFO address width; water level and word counters are ADDR_WIDTH+1 bits
- BYTES_PER_WORD, 4, tx_byte_num scale factor; must equal DATA_WIDTH/8
- IFG_CYCLES, 12, idle cycles enforced after tx_done before the next start; 0 allowed

Ports:
- clk  in  1  single clock, same as the FIFO rd_clk
- rst  in  1  reset, asynchronous, active-high
- cfg_pkt_words  in  ADDR_WIDTH+1  packet length in words; latched in IDLE only
- fifo_rd_data  in  DATA_WIDTH  FIFO rd_data
- fifo_empty  in  1  FIFO empty
- fifo_rd_level  in  ADDR_WIDTH+1  FIFO rd_water_level
- fifo_rd_en  out  1  FIFO read enable
- tx_start_en  out  1  one-cycle start pulse to the UDP TX core
- tx_byte_num  out  16  packet byte count, held stable from the start pulse until tx_done
- tx_req  in  1  TX core requests one word; data is expected on the next cycle
- tx_data  out  DATA_WIDTH  word to TX core; equals fifo_rd_data, combinational pass-through
- tx_done  in  1  one-cycle pulse when the TX core finishes a packet
- busy  out  1  high in every state except IDLE
- underflow_err  out  1  sticky flag; set when tx_req arrives in XFER while fifo_empty=1

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs are 0, including tx_byte_num, busy and underflow_err.
- States: IDLE, START, XFER, WAIT_DONE, GAP.
- IDLE
  - Each cycle, latch pkt_len=cfg_pkt_words.
  - Go to START when cfg_pkt_words!=0 and fifo_rd_level>=cfg_pkt_words.
  - cfg_pkt_words=0 keeps the block in IDLE.
- START
  - tx_start_en=1 for exactly one cycle.
  - tx_byte_num=pkt_len*BYTES_PER_WORD, truncated to 16 bits; otherwise it is held.
  - Next state is XFER. Start latency is one cycle after the qualifying edge.
- XFER
  - fifo_rd_en = tx_req && !fifo_empty && (rd_cnt<pkt_len), combinational.
  - rd_cnt increments on every fifo_rd_en.
  - FIFO data appears one cycle after fifo_rd_en, matching the TX core's req→data timing.
  - When rd_cnt reaches pkt_len (after the increment), go to WAIT_DONE.
  - tx_req while fifo_empty: no read, rd_cnt holds, underflow_err is set and stays set until rst.
  - tx_req after pkt_len words have been read is ignored.
- WAIT_DONE: fifo_rd_en=0; on tx_done go to GAP with gap_cnt=0.
- tx_done in START or XFER: an early abort. Go to GAP immediately, with no further reads. The unread words of the packet stay in the FIFO.
- GAP: gap_cnt counts to IFG_CYCLES, then go to IDLE. IFG_CYCLES=0 means GAP lasts one cycle.
- tx_req and tx_done in IDLE or GAP are ignored; fifo_rd_en is never asserted outside XFER.
- rst mid-packet: immediate return to IDLE. The FIFO shares rst, so no partial-packet state survives.
- Widths: rd_cnt and pkt_len are ADDR_WIDTH+1 bits, so a maximum packet of 1024 words is representable.

Optional Feature:
- Macro ETH_PKT_RD_SCHED_STATS_EN.
- When defined, add outputs stat_pkt_cnt[31:0] and stat_underflow_cnt[15:0].
  - stat_pkt_cnt increments on each tx_done accepted in WAIT_DONE.
  - stat_underflow_cnt increments per underflow cycle.
  - Both are reset to 0 and saturate at all-ones.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package eth_pkt_pkg:
  - state enum (IDLE, START, XFER, WAIT_DONE, GAP)
  - ETH_DATA_WIDTH=32, ETH_FIFO_AW=10, ETH_BYTE_NUM_W=16
- One sub-module, eth_pkt_gap_timer: load, count and expire for the IFG counter.
- FSM, read counter and flags remain in the top module.

Test Plan:
- Nominal packet
  - Stimulus: cfg=16; write words 1..16; level reaches 16; TX core issues 16 tx_req in consecutive cycles.
  - Response: tx_start_en pulses once, one cycle after level=16, with tx_byte_num=64; fifo_rd_en is high for 16 cycles; tx_data=1..16; tx_done is followed by 12 GAP cycles, then IDLE.
- Threshold hold-off
  - Stimulus: cfg=16, only 15 words written.
  - Response: no tx_start_en and busy=0; writing the 16th word triggers the start.
- Underflow
  - Stimulus: level forced to 16, FIFO drained externally to empty, tx_req=1 in XFER.
  - Response: fifo_rd_en=0, underflow_err=1 and remains set; rd_cnt holds.
- Early abort and config change
  - Stimulus: tx_done after 5 of 16 reads; cfg changed to 8 during XFER.
  - Response: GAP is entered immediately and 11 words remain in the FIFO; the next packet uses pkt_len=8 with tx_byte_num=32.
- Reset mid-packet
  - Stimulus: rst asserted during XFER.
  - Response: all outputs 0 asynchronously; after release, state=IDLE and no start occurs until the level threshold is met again.
- Back-to-back packets with IFG_CYCLES=0
  - Stimulus: 64 words buffered, cfg=32.
  - Response: two packets; the second tx_start_en occurs 3 cycles after the first tx_done (GAP, IDLE, START).
